weight_stream_reader: RTL and testbench

//  Read-side sequencer for memory_block weight storage. On a start command it

---
 rtl/weight_stream_reader.sv | 87 ++++++++
 tb/tb_weight_stream_reader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/weight_stream_reader.sv
// weight_stream_reader: walks a run of memory_block rows and streams them out over valid/ready.
// A credit check on fifo_count + inflight keeps the small output FIFO from ever overflowing.
module weight_stream_reader #(
    parameter int DATAW      = 128,
    parameter int DEPTH      = 64,
    parameter int ADDRW      = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   len,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] mem_raddr,
    input  logic [DATAW-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_last
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_n;
    logic [ADDRW:0] len_q, issued;
    logic [PW:0] count;
    logic [PW+1:0] credit;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic inflight, inflight_last;
    logic [DATAW-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic issue, last_issue, push, pop, launch;
    assign credit     = (PW+2)'(count) + (PW+2)'(inflight);
    assign issue      = state == RUN && credit < (PW+2)'(FIFO_DEPTH);
    assign last_issue = issue && issued == len_q - 1'b1;
    assign launch     = state == IDLE && start && len != '0;
    assign push       = inflight;
    assign pop        = out_valid && out_ready;
    assign busy       = state != IDLE;
    assign out_valid  = count != '0;
    assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last   = out_valid && fifo_last[rd_ptr];
    always_comb begin
        state_n = state;
        if (launch) state_n = RUN;
        if (last_issue) state_n = DRAIN;
        if (state == DRAIN && pop && out_last) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len_q         <= '0;
            issued        <= '0;
            mem_raddr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            inflight      <= issue;
            inflight_last <= last_issue;
            done          <= (state == IDLE && start && len == '0) || (state == DRAIN && pop && out_last);
            if (launch) begin
                len_q     <= len;
                issued    <= '0;
                mem_raddr <= base_addr;
            end else if (issue) begin
                issued    <= issued + 1'b1;
                mem_raddr <= mem_raddr == ADDRW'(DEPTH - 1) ? '0 : mem_raddr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end
endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader: directed checks of latency, wrap, credit, len=0, abort and restart-ignore.
module tb_weight_stream_reader;
    localparam int DATAW = 128;
    localparam int DEPTH = 64;
    localparam int ADDRW = 6;
    logic clk = 1'b0;
    logic rst, start, busy, done, out_valid, out_ready, out_last;
    logic [ADDRW-1:0] base_addr, mem_raddr;
    logic [ADDRW:0] len;
    logic [DATAW-1:0] mem_rdata, out_data;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    always #5 clk = ~clk;
    weight_stream_reader #(.DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );
    function automatic logic [DATAW-1:0] row_of(input int k);
        return {64'hA5A5_0000_0000_0000 | 64'(k), 64'(k)};
    endfunction
    always @(posedge clk) mem_rdata <= row_of(int'(mem_raddr));
    always @(negedge clk) if (done) done_cnt++;
    task automatic chk(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic run(input int base, input int n, input int stalls, input int abort_at, input bit poke);
        int i = 0;
        int cyc = 1;
        int stall = 0;
        int d0;
        bit seen = 0;
        start = 1'b1;
        base_addr = ADDRW'(base);
        len = (ADDRW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        chk("raddr_base", mem_raddr, base);
        chk("busy_run", busy, 1);
        while (i < n && i != abort_at && cyc < 200) begin
            if (out_valid && !seen) begin
                seen = 1;
                stall = stalls;
                chk("latency", cyc, 3);
            end
            out_ready = stall == 0;
            if (stalls > 0 && stall == 1) chk("credit_raddr", mem_raddr, (base + 4) % DEPTH);
            if (stall > 0) stall--;
            start = poke && cyc == 5;
            if (out_valid && out_ready) begin
                chk("data", out_data, row_of((base + i) % DEPTH));
                chk("last", out_last, i == n - 1);
                if (stalls == 0) chk("throughput", cyc, 3 + i);
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (i != abort_at) begin
            chk("rows", i, n);
            chk("done", done, 1);
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("done_once", done_cnt - d0, 1);
            chk("no_extra", out_valid, 0);
        end
    endtask
    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        base_addr = '0;
        len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run(0, 4, 0, -1, 0);
        run(62, 4, 0, -1, 0);
        start = 1'b1;
        base_addr = 6'd40;
        len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_raddr", mem_raddr, 2);
        @(posedge clk); #1;
        chk("len0_done_end", done, 0);
        chk("len0_busy_end", busy, 0);
        chk("len0_valid", out_valid, 0);
        run(0, 8, 10, -1, 0);
        run(5, 6, 0, -1, 1);
        run(60, 64, 0, -1, 0);
        d0 = done_cnt;
        run(30, 8, 0, 3, 0);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_raddr", mem_raddr, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        chk("abort_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_done", done_cnt - d0, 0);
        run(10, 2, 0, -1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
